// File: rtl/sat_add_pkg.sv
// Shared definitions for the time-shared saturating adder: limit constants,
// FSM encoding and a width helper.
package sat_add_pkg;

   localparam int SAT_W = 24;

   // Negative limit is symmetric with the positive one on purpose.
   localparam logic [SAT_W-1:0] SAT_POS = 24'h7F_FFFF;
   localparam logic [SAT_W-1:0] SAT_NEG = 24'h80_0001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic int clog2_f(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << r) < value) begin
            r = r + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sat_add24.sv
// Combinational two's-complement adder that clamps overflow to a symmetric
// range, flagging whenever the clamp was applied.
module sat_add24
   import sat_add_pkg::*;
#(
   parameter int W1 = SAT_W
) (
   input  logic [W1-1:0] a,
   input  logic [W1-1:0] b,
   output logic [W1-1:0] sum,
   output logic          sat
);

   localparam logic [W1-1:0] POS_LIM = {1'b0, {(W1-1){1'b1}}};
   localparam logic [W1-1:0] NEG_LIM = {1'b1, {(W1-2){1'b0}}, 1'b1};

   logic [W1-1:0] raw_s;
   logic          pos_ovf_s;
   logic          neg_ovf_s;

   // Overflow is only possible when both operands share a sign.
   always_comb begin
      raw_s     = a + b;
      pos_ovf_s = ~a[W1-1] & ~b[W1-1] &  raw_s[W1-1];
      neg_ovf_s =  a[W1-1] &  b[W1-1] & ~raw_s[W1-1];
      sat       = pos_ovf_s | neg_ovf_s;
      if (pos_ovf_s) begin
         sum = POS_LIM;
      end else if (neg_ovf_s) begin
         sum = NEG_LIM;
      end else begin
         sum = raw_s;
      end
   end

endmodule

// File: rtl/sat_add_arbiter.sv
// Round-robin scheduler sharing one saturating adder among N_REQ requesters,
// with registered response and a sticky saturation-event counter.
module sat_add_arbiter
   import sat_add_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W1    = 24,
   parameter int IDW   = clog2_f(N_REQ),
   parameter int CNTW  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*W1-1:0] data_a,
   input  logic [N_REQ*W1-1:0] data_b,
   input  logic               cnt_clr,
   output logic [N_REQ-1:0]    ack,
   output logic [W1-1:0]       sum_out,
   output logic [IDW-1:0]      sum_id,
   output logic               sum_valid,
   output logic               sat,
   output logic               busy,
   output logic [CNTW-1:0]     sat_cnt
);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [IDW-1:0]    ptr_r;
   logic [IDW-1:0]    id_r;
   logic [IDW-1:0]    win_s;
   logic              win_vld_s;
   logic [W1-1:0]     opa_r;
   logic [W1-1:0]     opb_r;
   logic [W1-1:0]     add_sum_s;
   logic              add_sat_s;
   logic [W1-1:0]     res_r;
   logic              res_sat_r;
   logic [N_REQ-1:0]  ack_r;
   logic [W1-1:0]     sum_out_r;
   logic [IDW-1:0]    sum_id_r;
   logic              sum_valid_r;
   logic              sat_r;
   logic              busy_r;
   logic [CNTW-1:0]   sat_cnt_r;

   sat_add24 #(.W1(W1)) u_add (
      .a   (opa_r),
      .b   (opb_r),
      .sum (add_sum_s),
      .sat (add_sat_s)
   );

   // Round-robin pick: first active request at or after the pointer.
   always_comb begin
      int idx_v;
      win_vld_s = 1'b0;
      win_s     = {IDW{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         idx_v = (int'(ptr_r) + k) % N_REQ;
         if (!win_vld_s && req[idx_v]) begin
            win_vld_s = 1'b1;
            win_s     = IDW'(idx_v);
         end else begin
            win_vld_s = win_vld_s;
         end
      end
   end

   // Next-state logic; every transition is gated by the global enable.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (en && win_vld_s) begin
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (en) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_EXEC;
            end
         end
         ST_RESP: begin
            if (en) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand capture at grant and result capture in EXEC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_r      <= {IDW{1'b0}};
         opa_r     <= {W1{1'b0}};
         opb_r     <= {W1{1'b0}};
         res_r     <= {W1{1'b0}};
         res_sat_r <= 1'b0;
      end else if (en) begin
         case (state_r)
            ST_IDLE: begin
               if (win_vld_s) begin
                  id_r  <= win_s;
                  opa_r <= data_a[int'(win_s)*W1 +: W1];
                  opb_r <= data_b[int'(win_s)*W1 +: W1];
               end
            end
            ST_EXEC: begin
               res_r     <= add_sum_s;
               res_sat_r <= add_sat_s;
            end
            default: begin
               res_sat_r <= res_sat_r;
            end
         endcase
      end
   end

   // Response pulses, held result and pointer advance. Pulses only fire on enabled edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_r       <= {N_REQ{1'b0}};
         sum_valid_r <= 1'b0;
         sat_r       <= 1'b0;
         busy_r      <= 1'b0;
         sum_out_r   <= {W1{1'b0}};
         sum_id_r    <= {IDW{1'b0}};
         ptr_r       <= {IDW{1'b0}};
      end else if (en) begin
         ack_r       <= {N_REQ{1'b0}};
         sum_valid_r <= 1'b0;
         sat_r       <= 1'b0;
         busy_r      <= (state_nxt_s != ST_IDLE) || (state_r == ST_RESP);
         if (state_r == ST_RESP) begin
            ack_r[id_r] <= 1'b1;
            sum_valid_r <= 1'b1;
            sat_r       <= res_sat_r;
            sum_out_r   <= res_r;
            sum_id_r    <= id_r;
            ptr_r       <= (id_r == IDW'(N_REQ-1)) ? {IDW{1'b0}} : id_r + 1'b1;
         end
      end else begin
         ack_r       <= {N_REQ{1'b0}};
         sum_valid_r <= 1'b0;
         sat_r       <= 1'b0;
      end
   end

   // Saturation-event counter; clear beats a coincident increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sat_cnt_r <= {CNTW{1'b0}};
      end else if (en) begin
         if (cnt_clr) begin
            sat_cnt_r <= {CNTW{1'b0}};
         end else if ((state_r == ST_RESP) && res_sat_r && (sat_cnt_r != {CNTW{1'b1}})) begin
            sat_cnt_r <= sat_cnt_r + 1'b1;
         end
      end
   end

   assign ack       = ack_r;
   assign sum_out   = sum_out_r;
   assign sum_id    = sum_id_r;
   assign sum_valid = sum_valid_r;
   assign sat       = sat_r;
   assign busy      = busy_r;
   assign sat_cnt   = sat_cnt_r;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Directed bench for sat_add_arbiter; a narrow counter keeps the
// counter-saturation case short.
module tb_sat_add_arbiter;
   import sat_add_pkg::*;

   localparam int N_REQ = 4;
   localparam int W1    = 24;
   localparam int IDW   = 2;
   localparam int CNTW  = 5;
   localparam int CMAX  = 31;

   logic               clk;
   logic               reset;
   logic               en;
   logic [N_REQ-1:0]    req;
   logic [N_REQ*W1-1:0] data_a;
   logic [N_REQ*W1-1:0] data_b;
   logic               cnt_clr;
   logic [N_REQ-1:0]    ack;
   logic [W1-1:0]       sum_out;
   logic [IDW-1:0]      sum_id;
   logic               sum_valid;
   logic               sat;
   logic               busy;
   logic [CNTW-1:0]     sat_cnt;

   int total;
   int bad;

   sat_add_arbiter #(.N_REQ(N_REQ), .W1(W1), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .en(en), .req(req),
      .data_a(data_a), .data_b(data_b), .cnt_clr(cnt_clr),
      .ack(ack), .sum_out(sum_out), .sum_id(sum_id), .sum_valid(sum_valid),
      .sat(sat), .busy(busy), .sat_cnt(sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [W1-1:0] a, input logic [W1-1:0] b);
      data_a[i*W1 +: W1] = a;
      data_b[i*W1 +: W1] = b;
   endtask

   // Counts falling edges until ack shows; a timeout shows up as a latency miss.
   task automatic wait_ack(input string tag, input int exp_cyc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack == 4'b0000 && n < 40);
      chk(tag, 32'(n), 32'(exp_cyc));
   endtask

   logic [W1-1:0] rr_a   [4] = '{24'h010000, 24'h020000, 24'h030000, 24'h040000};
   logic [W1-1:0] rr_b   [4] = '{24'h000101, 24'h000202, 24'h000303, 24'h000404};
   logic [W1-1:0] rr_sum [4] = '{24'h010101, 24'h020202, 24'h030303, 24'h040404};

   initial begin
      total   = 0;
      bad     = 0;
      reset   = 1'b0;
      en      = 1'b1;
      req     = 4'b0000;
      cnt_clr = 1'b0;
      data_a  = '0;
      data_b  = '0;
      repeat (2) @(negedge clk);
      chk("rst_ack",   32'(ack),       32'h0);
      chk("rst_valid", 32'(sum_valid), 32'h0);
      chk("rst_busy",  32'(busy),      32'h0);
      chk("rst_sum",   32'(sum_out),   32'h0);
      chk("rst_cnt",   32'(sat_cnt),   32'h0);
      reset = 1'b1;
      @(negedge clk);

      // positive saturation
      set_op(0, 24'h400000, 24'h400000);
      req = 4'b0001;
      wait_ack("pos_lat", 3);
      chk("pos_ack", 32'(ack),       32'h1);
      chk("pos_sum", 32'(sum_out),   32'(SAT_POS));
      chk("pos_sat", 32'(sat),       32'h1);
      chk("pos_vld", 32'(sum_valid), 32'h1);
      chk("pos_id",  32'(sum_id),    32'h0);
      chk("pos_cnt", 32'(sat_cnt),   32'h1);
      req = 4'b0000;
      @(negedge clk);
      chk("pos_ack_off",  32'(ack),     32'h0);
      chk("pos_busy_off", 32'(busy),    32'h0);
      chk("pos_hold",     32'(sum_out), 32'(SAT_POS));

      // negative saturation, then the most-negative non-saturating case
      set_op(1, 24'hC00000, 24'hBFFFFF);
      req = 4'b0010;
      wait_ack("neg_lat", 3);
      chk("neg_ack", 32'(ack),     32'h2);
      chk("neg_sum", 32'(sum_out), 32'(SAT_NEG));
      chk("neg_sat", 32'(sat),     32'h1);
      chk("neg_cnt", 32'(sat_cnt), 32'h2);
      req = 4'b0000;
      @(negedge clk);
      set_op(1, 24'h800000, 24'h000000);
      req = 4'b0010;
      wait_ack("edge_lat", 3);
      chk("edge_sum", 32'(sum_out), 32'h800000);
      chk("edge_sat", 32'(sat),     32'h0);
      chk("edge_id",  32'(sum_id),  32'h1);
      chk("edge_cnt", 32'(sat_cnt), 32'h2);
      req = 4'b0000;
      @(negedge clk);

      // mixed sign on requester 3 wraps the pointer back to 0
      set_op(3, 24'h000005, 24'hFFFFFE);
      req = 4'b1000;
      wait_ack("mix_lat", 3);
      chk("mix_sum", 32'(sum_out), 32'h000003);
      chk("mix_sat", 32'(sat),     32'h0);
      req = 4'b0000;
      @(negedge clk);

      // round-robin fairness with all requesters held
      for (int i = 0; i < 4; i++) set_op(i, rr_a[i], rr_b[i]);
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         wait_ack($sformatf("rr_lat%0d", j), 3);
         chk($sformatf("rr_ack%0d", j), 32'(ack),     32'(1) << (j % 4));
         chk($sformatf("rr_id%0d", j),  32'(sum_id),  32'(j % 4));
         chk($sformatf("rr_sum%0d", j), 32'(sum_out), 32'(rr_sum[j % 4]));
      end
      req = 4'b0000;
      @(negedge clk);

      // enable freeze for 5 cycles during EXEC
      set_op(2, 24'h123456, 24'h111111);
      req = 4'b0100;
      @(negedge clk);
      chk("frz_busy", 32'(busy), 32'h1);
      en = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk($sformatf("frz_ack%0d", j), 32'(ack),     32'h0);
         chk($sformatf("frz_sum%0d", j), 32'(sum_out), 32'h010101);
      end
      en = 1'b1;
      wait_ack("frz_lat", 2);
      chk("frz_ack", 32'(ack),     32'h4);
      chk("frz_sum", 32'(sum_out), 32'h234567);
      chk("frz_id",  32'(sum_id),  32'h2);
      req = 4'b0000;
      @(negedge clk);

      // reset in EXEC drops the operation and rewinds the pointer
      req = 4'b1000;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mrst_ack",  32'(ack),       32'h0);
      chk("mrst_vld",  32'(sum_valid), 32'h0);
      chk("mrst_sum",  32'(sum_out),   32'h0);
      chk("mrst_id",   32'(sum_id),    32'h0);
      chk("mrst_busy", 32'(busy),      32'h0);
      chk("mrst_cnt",  32'(sat_cnt),   32'h0);
      @(negedge clk);
      chk("mrst_noack", 32'(ack), 32'h0);
      reset = 1'b1;
      req   = 4'b1111;
      wait_ack("mrst_lat", 3);
      chk("mrst_first", 32'(ack),     32'h1);
      chk("mrst_fsum",  32'(sum_out), 32'h010101);
      req = 4'b0000;
      @(negedge clk);

      // counter sticks at all-ones
      set_op(0, 24'h400000, 24'h400000);
      req = 4'b0001;
      for (int j = 0; j < CMAX + 3; j++) begin
         wait_ack($sformatf("cnt_lat%0d", j), 3);
         chk($sformatf("cnt%0d", j), 32'(sat_cnt), 32'((j + 1 > CMAX) ? CMAX : j + 1));
      end

      // clear coincident with a saturating result wins
      @(negedge clk);
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      chk("clr_ack", 32'(ack),     32'h1);
      chk("clr_sat", 32'(sat),     32'h1);
      chk("clr_cnt", 32'(sat_cnt), 32'h0);
      cnt_clr = 1'b0;
      req     = 4'b0000;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
